// File: rtl/deal_pkg.sv
`default_nettype none
// ============================================================================
// Module      : deal_pkg
// Description : Shared types and constants for the baccarat deal controller:
//               FSM state enum, card-code constants, natural/draw thresholds
//               and a helper mapping a raw card code to its point value.
// Revision    : 1.0  initial release
// ============================================================================
package deal_pkg;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    P1    = 4'd1,
    D1    = 4'd2,
    P2    = 4'd3,
    D2    = 4'd4,
    CHECK = 4'd5,
    P3    = 4'd6,
    BANK  = 4'd7,
    D3    = 4'd8,
    DONE  = 4'd9,
    CLEAR = 4'd10
  } deal_state_e;

  // Raw card codes
  localparam logic [3:0] ACE  = 4'd1;
  localparam logic [3:0] TEN  = 4'd10;
  localparam logic [3:0] KING = 4'd13;

  // Score thresholds
  localparam logic [3:0] NATURAL_LO             = 4'd8;
  localparam logic [3:0] NATURAL_HI             = 4'd9;
  localparam logic [3:0] PLAYER_DRAW_MAX        = 4'd5;
  localparam logic [3:0] DEALER_DRAW_MAX        = 4'd5;  // player stood
  localparam logic [3:0] BANKER_ALWAYS_DRAW_MAX = 4'd2;

  // Last value of the DONE hold counter before a new hand starts
  localparam logic [2:0] HOLD_LAST = 3'd7;

  // Ten and face cards count zero; every other code counts its face value.
  function automatic logic [3:0] card_value(input logic [3:0] code);
    return (code >= TEN && code <= KING) ? 4'd0 : code;
  endfunction

  // Only 8 and 9 are naturals; out-of-range scores never are.
  function automatic logic is_natural(input logic [3:0] score);
    return (score == NATURAL_LO) || (score == NATURAL_HI);
  endfunction

endpackage
`default_nettype wire

// File: rtl/banker_rule.sv
`default_nettype none
// ============================================================================
// Module      : banker_rule
// Description : Combinational banker third-card decision, used after the
//               player has drawn a third card.
// Ports       : dscore_i  [3:0] banker score (values >9 never draw)
//               pcard3_i  [3:0] raw code of the player's third card
//               draw_o          1 = banker draws a third card
// Revision    : 1.0  initial release
// ============================================================================
module banker_rule
  import deal_pkg::*;
(
  input  logic [3:0] dscore_i,
  input  logic [3:0] pcard3_i,
  output logic       draw_o
);

  logic [3:0] v_w;

  always_comb begin
    v_w    = card_value(pcard3_i);
    draw_o = 1'b0;
    if (dscore_i <= BANKER_ALWAYS_DRAW_MAX) begin
      draw_o = 1'b1;
    end else begin
      case (dscore_i)
        4'd3:    draw_o = (v_w != 4'd8);
        4'd4:    draw_o = (v_w >= 4'd2) && (v_w <= 4'd7);
        4'd5:    draw_o = (v_w >= 4'd4) && (v_w <= 4'd7);
        4'd6:    draw_o = (v_w >= 4'd6) && (v_w <= 4'd7);
        default: draw_o = 1'b0;  // 7 and out-of-range scores stand
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/deal_controller.sv
`default_nettype none
// ============================================================================
// Module      : deal_controller
// Description : Baccarat dealing sequencer. Walks the fixed four-card deal,
//               applies the player and banker third-card rules, and shows the
//               hand result. All outputs are registered Moore decodes of the
//               state being entered.
// Ports       : slow_clock            clock, rising edge
//               resetb                asynchronous active-low reset
//               pscore/dscore   [3:0] player/dealer hand scores
//               pcard3          [3:0] raw code of the player third card
//               load_pcard1..3        player card register load strobes
//               load_dcard1..3        dealer card register load strobes
//               player_win_light      player score >= dealer score in DONE
//               dealer_win_light      dealer score >= player score in DONE
//               clear_hands           one-cycle clear of all card registers
// Config      : DEAL_AUTO_NEW_HAND_EN  when defined, DONE is held for eight
//               cycles, then CLEAR pulses clear_hands and a new hand starts.
//               When undefined, DONE is absorbing and clear_hands is 0.
// Revision    : 1.0  initial release
// ============================================================================
module deal_controller
  import deal_pkg::*;
(
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light,
  output logic       clear_hands
);

  deal_state_e state_q, state_d;
  logic        banker_draw;

  banker_rule u_banker_rule (
    .dscore_i (dscore),
    .pcard3_i (pcard3),
    .draw_o   (banker_draw)
  );

`ifdef DEAL_AUTO_NEW_HAND_EN
  logic [2:0] hold_q, hold_d;
`endif

  // Next-state logic
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:  state_d = P1;
      P1:    state_d = D1;
      D1:    state_d = P2;
      P2:    state_d = D2;
      D2:    state_d = CHECK;
      CHECK: begin
        if (is_natural(pscore) || is_natural(dscore)) begin
          state_d = DONE;
        end else if (pscore <= PLAYER_DRAW_MAX) begin
          state_d = P3;
        end else if (dscore <= DEALER_DRAW_MAX) begin
          state_d = D3;
        end else begin
          state_d = DONE;
        end
      end
      P3:    state_d = BANK;
      BANK:  state_d = banker_draw ? D3 : DONE;
      D3:    state_d = DONE;
`ifdef DEAL_AUTO_NEW_HAND_EN
      DONE:  state_d = (hold_q == HOLD_LAST) ? CLEAR : DONE;
      CLEAR: state_d = P1;
`else
      DONE:  state_d = DONE;
`endif
      default: state_d = IDLE;  // unused encodings recover to IDLE
    endcase
  end

`ifdef DEAL_AUTO_NEW_HAND_EN
  // Counts cycles spent in DONE; restarts at 0 each time DONE is entered.
  always_comb begin
    hold_d = 3'd0;
    if (state_q == DONE && state_d == DONE) begin
      hold_d = hold_q + 3'd1;
    end
  end
`endif

  // State and registered outputs, decoded from the state being entered so
  // each output is valid for exactly the cycle spent in its state.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state_q          <= IDLE;
      load_pcard1      <= 1'b0;
      load_pcard2      <= 1'b0;
      load_pcard3      <= 1'b0;
      load_dcard1      <= 1'b0;
      load_dcard2      <= 1'b0;
      load_dcard3      <= 1'b0;
      player_win_light <= 1'b0;
      dealer_win_light <= 1'b0;
`ifdef DEAL_AUTO_NEW_HAND_EN
      clear_hands      <= 1'b0;
      hold_q           <= 3'd0;
`endif
    end else begin
      state_q          <= state_d;
      load_pcard1      <= (state_d == P1);
      load_pcard2      <= (state_d == P2);
      load_pcard3      <= (state_d == P3);
      load_dcard1      <= (state_d == D1);
      load_dcard2      <= (state_d == D2);
      load_dcard3      <= (state_d == D3);
      // A tie lights both lamps.
      player_win_light <= (state_d == DONE) && (pscore >= dscore);
      dealer_win_light <= (state_d == DONE) && (dscore >= pscore);
`ifdef DEAL_AUTO_NEW_HAND_EN
      clear_hands      <= (state_d == CLEAR);
      hold_q           <= hold_d;
`endif
    end
  end

`ifndef DEAL_AUTO_NEW_HAND_EN
  assign clear_hands = 1'b0;
`endif

endmodule
`default_nettype wire
